// File: rtl/config_pkg.sv
// System-level clock and baud settings shared by the UART blocks.
package config_pkg;

   localparam int ClkFreqHz      = 100_000_000;
   localparam int BaudRate       = 115_200;
   localparam int UartClksPerBit = ClkFreqHz / BaudRate;

endpackage : config_pkg

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

   localparam int UartDataBits = 8;
   localparam int UartBitCntW  = $clog2(UartDataBits);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage : uart_pkg

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..ClksPerBit-1 and flags the last cycle of each bit.
// Holding i_clear keeps the count at zero so the next bit starts on a full period.
module baud_tick #(
   parameter int ClksPerBit = 868
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int              CntW    = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

   logic [CntW-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CntW'(1);
      end
   end

   assign o_tick = !i_clear && (r_count == LastCnt);

endmodule : baud_tick

// File: rtl/uart_tx.sv
// UART transmitter: pops one byte per frame from the FIFO and sends it 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int ClksPerBit = config_pkg::UartClksPerBit
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    have_next_i,
   input  logic [UartDataBits-1:0] data_i,
   output logic                    next_o,
   output logic                    tx_o,
   output logic                    busy_o
);

   localparam logic [UartBitCntW-1:0] LastBit = UartBitCntW'(UartDataBits - 1);

   tx_state_e               r_state;
   tx_state_e               w_state_nxt;
   logic [UartDataBits-1:0] r_shift;
   logic [UartDataBits-1:0] w_shift_nxt;
   logic [UartBitCntW-1:0]  r_bit_cnt;
   logic [UartBitCntW-1:0]  w_bit_cnt_nxt;
   logic                    r_tx;
   logic                    r_next;
   logic                    r_busy;
   logic                    w_tx_nxt;
   logic                    w_next_nxt;
   logic                    w_busy_nxt;
   logic                    w_tick;
   logic                    w_baud_clear;

`ifdef UART_TX_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_parity <= 1'b0;
      end else if (r_state == IDLE && have_next_i) begin
         r_parity <= ^data_i;
      end
   end
`endif

   // Counter is held at zero while idle so the start bit gets a full period.
   assign w_baud_clear = (r_state == IDLE);

   baud_tick #(
      .ClksPerBit (ClksPerBit)
   ) u_baud_tick (
      .i_clk   (clk_i),
      .i_rst   (reset_i),
      .i_clear (w_baud_clear),
      .o_tick  (w_tick)
   );

   // NOTE: every combinational output gets a default first; a missed branch would infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_next_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (have_next_i) begin
               w_state_nxt = START;
               w_shift_nxt = data_i;
               w_next_nxt  = 1'b1;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_nxt   = r_shift >> 1;
               w_bit_cnt_nxt = r_bit_cnt + UartBitCntW'(1);
               if (r_bit_cnt == LastBit) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_tick) begin
               w_state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (w_tick) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Outputs are decoded from the upcoming state so the registered pins line up with it.
      w_busy_nxt = (w_state_nxt != IDLE);
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_nxt = r_parity;
`endif
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_next    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx      <= w_tx_nxt;
         r_next    <= w_next_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign tx_o   = r_tx;
   assign next_o = r_next;
   assign busy_o = r_busy;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a FIFO model feeds bytes, a monitor checks each frame bit by bit.
// Follows UART_TX_PARITY_EN to expect 8E1 instead of 8N1 frames.
module tb_uart_tx;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FrameBits = 11;
`else
   localparam int FrameBits = 10;
`endif
   localparam int FrameCycles = FrameBits * C;

   logic       clk;
   logic       reset_i;
   logic       have_next_i;
   logic [7:0] data_i;
   logic       next_o;
   logic       tx_o;
   logic       busy_o;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         pop_count = 0;
   int         busy_cycles = 0;
   bit         in_frame = 1'b0;
   logic [7:0] idle_data = 8'h00;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         pop_cyc_q[$];

   uart_tx #(
      .ClksPerBit (C)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .have_next_i (have_next_i),
      .data_i      (data_i),
      .next_o      (next_o),
      .tx_o        (tx_o),
      .busy_o      (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return ((b >> (idx - 1)) & 8'd1) != 8'd0;
      if (idx == 9 && FrameBits == 11) return ($countones(b) % 2) == 1;
      return 1'b1;
   endfunction

   // FIFO model: pops on a sampled next_o pulse, presents the head byte combinationally.
   initial begin
      logic [7:0] junk;
      have_next_i = 1'b0;
      data_i      = 8'h00;
      forever begin
         @(negedge clk);
         if (busy_o) busy_cycles++;
         if (next_o) begin
            pop_count++;
            pop_cyc_q.push_back(cyc);
            check("pop_from_nonempty_fifo", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) junk = fifo_q.pop_front();
         end
         have_next_i = (fifo_q.size() != 0);
         data_i      = have_next_i ? fifo_q[0] : idle_data;
      end
   end

   // Monitor: each pop starts a frame whose every cycle is compared with the model.
   initial begin : monitor
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            check("reset_outputs", {tx_o, next_o, busy_o}, 3'b100);
         end else if (next_o) begin
            if (exp_q.size() == 0) begin
               check("pop_expected", 0, 1);
            end else begin
               b = exp_q.pop_front();
               in_frame = 1'b1;
               for (int k = 0; k < FrameCycles; k++) begin
                  if (k > 0) begin
                     @(negedge clk);
                     if (reset_i) break;
                  end
                  check($sformatf("frame_%02h_bit%0d_tx_busy_next", b, k / C),
                        {tx_o, busy_o, next_o}, {frame_bit(b, k / C), 1'b1, k == 0});
               end
               in_frame = 1'b0;
            end
         end else begin
            check("idle_tx_busy", {tx_o, busy_o}, 2'b10);
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || in_frame) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, n < limit, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_pop(input int pc, input string name);
      int n = 0;
      while (pop_count == pc && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, n < 200, 1);
   endtask

   initial begin : main
      int pc;
      int bc;
      int bad;
      int s;
      logic [7:0] b;

      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx_o, 1);
      check("reset_next", next_o, 0);
      check("reset_busy", busy_o, 0);
      reset_i = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {tx_o, next_o, busy_o}, 3'b100);

      // Single byte 0xA5: one pop, busy for exactly one frame.
      pc = pop_count;
      bc = busy_cycles;
      push_byte(8'hA5);
      wait_drain("a5_drain", 500);
      check("a5_pop_count", pop_count - pc, 1);
      check("a5_busy_cycles", busy_cycles - bc, FrameCycles);

      // Back-to-back 0x00 then 0xFF: one idle cycle between frames, no extra pop.
      pc = pop_count;
      push_byte(8'h00);
      push_byte(8'hFF);
      wait_drain("b2b_drain", 500);
      check("b2b_pop_count", pop_count - pc, 2);
      if (pop_cyc_q.size() >= 2)
         check("b2b_pop_spacing", pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-2],
               FrameCycles + 1);
      repeat (100) @(negedge clk);
      check("b2b_no_third_pop", pop_count - pc, 2);

      // Empty FIFO for 1000 cycles: line stays idle.
      pc  = pop_count;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || next_o !== 1'b0 || busy_o !== 1'b0) bad++;
      end
      check("idle_1000_bad_cycles", bad, 0);
      check("idle_1000_no_pop", pop_count - pc, 0);

      // Asynchronous reset during data bit 3 (tx low for 0xF0), then a clean frame.
      pc = pop_count;
      push_byte(8'hF0);
      wait_pop(pc, "rst_first_pop");
      s = (pop_cyc_q.size() != 0) ? pop_cyc_q[pop_cyc_q.size()-1] : cyc;
      while (cyc < s + 4 * C + 1) @(negedge clk);
      #2;
      reset_i = 1'b1;
      #1;
      check("async_rst_tx", tx_o, 1);
      check("async_rst_busy", busy_o, 0);
      check("async_rst_next", next_o, 0);
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      pc = pop_count;
      push_byte(8'h5A);
      wait_drain("post_rst_drain", 500);
      check("post_rst_pop_count", pop_count - pc, 1);

      // data_i moves to 0x55 mid-frame; the frame must still carry 0x3C.
      idle_data = 8'hC3;
      pc = pop_count;
      push_byte(8'h3C);
      wait_pop(pc, "data_change_pop");
      idle_data = 8'h55;
      wait_drain("data_change_drain", 500);

      // Parity corner bytes (odd and even count of ones).
      bc = busy_cycles;
      push_byte(8'h07);
      wait_drain("byte07_drain", 500);
      check("byte07_frame_cycles", busy_cycles - bc, FrameCycles);
      push_byte(8'h03);
      wait_drain("byte03_drain", 500);

      // Randomized traffic with random gaps and garbage on data_i while empty.
      pc = pop_count;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3 * FrameCycles)) @(negedge clk);
         idle_data = 8'($urandom);
         b = 8'($urandom);
         push_byte(b);
      end
      wait_drain("random_drain", 5000);
      check("random_pop_count", pop_count - pc, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_tx
